mem_pingpong_ctrl: RTL and testbench

//  Two-bank ping-pong frame buffer controller between a streaming producer
//  (framing/windowing) and the FFT core. Writer fills one single-port SRAM bank

---
 rtl/mem_pingpong_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_pingpong_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_pingpong_ctrl
// Brief    : Two-bank ping-pong frame buffer between a streaming producer and
//            an FFT reader. One bank fills sequentially while the other is read.
//            Optional in-place FFT write-back: define MEM_INPLACE_WB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_pingpong_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int FRAME_LEN  = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_done,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  bank_ready,
  output logic                  frame_start,
  output logic                  mem_sel,
`ifdef MEM_INPLACE_WB_EN
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rd_collision,
`endif
  output logic                  cen_1,
  output logic                  wen_1,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic [DATA_WIDTH-1:0] d_1,
  input  logic [DATA_WIDTH-1:0] q_1,
  output logic                  cen_2,
  output logic                  wen_2,
  output logic [ADDR_WIDTH-1:0] addr_2,
  output logic [DATA_WIDTH-1:0] d_2,
  input  logic [DATA_WIDTH-1:0] q_2
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(FRAME_LEN - 1);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_wr_cnt;
  logic                  r_mem_sel;
  logic                  r_rd_sel;
  logic                  r_rd_valid;
  logic                  r_frame_start;

  logic                  w_wr_xfer;
  logic                  w_last;
  logic                  w_done;
  logic                  w_swap;
  logic                  w_rd_acc;
  logic                  w_rd_cen;
  logic                  w_rd_wen;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] w_rd_d;

  assign bank_ready  = (r_state != ST_FILL);
  assign wr_ready    = (r_state != ST_HOLD);
  assign mem_sel     = r_mem_sel;
  assign frame_start = r_frame_start;
  assign rd_valid    = r_rd_valid;

  assign w_wr_xfer = wr_valid & wr_ready;
  assign w_last    = w_wr_xfer & (r_wr_cnt == c_last_addr);
  assign w_done    = rd_done & bank_ready;

`ifdef MEM_INPLACE_WB_EN
  logic w_wb_acc;
  logic r_rd_collision;

  // Write-back wins the read-bank port; the colliding read is dropped.
  assign w_wb_acc     = wb_en & bank_ready;
  assign w_rd_acc     = rd_en & bank_ready & ~wb_en;
  assign w_rd_cen     = w_rd_acc | w_wb_acc;
  assign w_rd_wen     = w_wb_acc;
  assign w_rd_addr    = w_wb_acc ? wb_addr : rd_addr;
  assign w_rd_d       = wb_data;
  assign rd_collision = r_rd_collision;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_collision <= 1'b0;
    end else begin
      r_rd_collision <= w_wb_acc & rd_en;
    end
  end
`else
  assign w_rd_acc  = rd_en & bank_ready;
  assign w_rd_cen  = w_rd_acc;
  assign w_rd_wen  = 1'b0;
  assign w_rd_addr = rd_addr;
  assign w_rd_d    = '0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_swap       = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_last) begin
          w_swap       = 1'b1;
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (w_last && w_done) begin
          w_swap = 1'b1;
        end else if (w_last) begin
          w_state_next = ST_HOLD;
        end else if (w_done) begin
          w_state_next = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (w_done) begin
          w_swap       = 1'b1;
          w_state_next = ST_STREAM;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_FILL;
      r_wr_cnt      <= '0;
      r_mem_sel     <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_xfer) begin
        r_wr_cnt <= w_last ? '0 : r_wr_cnt + 1'b1;
      end
      if (w_swap) begin
        r_mem_sel <= ~r_mem_sel;
      end
      r_frame_start <= w_swap;
      r_rd_valid    <= w_rd_acc;
      // Bank the returning data came from, not the bank selected now.
      r_rd_sel      <= r_mem_sel;
    end
  end

  assign rd_data = r_rd_valid ? (r_rd_sel ? q_1 : q_2) : '0;

  always_comb begin
    if (r_mem_sel) begin
      cen_1  = w_rd_cen;
      wen_1  = w_rd_wen;
      addr_1 = w_rd_addr;
      d_1    = w_rd_d;
      cen_2  = w_wr_xfer;
      wen_2  = w_wr_xfer;
      addr_2 = r_wr_cnt;
      d_2    = wr_data;
    end else begin
      cen_1  = w_wr_xfer;
      wen_1  = w_wr_xfer;
      addr_1 = r_wr_cnt;
      d_1    = wr_data;
      cen_2  = w_rd_cen;
      wen_2  = w_rd_wen;
      addr_2 = w_rd_addr;
      d_2    = w_rd_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_pingpong_ctrl
// Brief    : Self-checking bench for mem_pingpong_ctrl with frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_pingpong_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int FL = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid, wr_ready, rd_en, rd_done, rd_valid;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW-1:0] rd_addr;
  logic          bank_ready, frame_start, mem_sel;
  logic          cen_1, wen_1, cen_2, wen_2;
  logic [AW-1:0] addr_1, addr_2;
  logic [DW-1:0] d_1, d_2, q_1, q_2;
`ifdef MEM_INPLACE_WB_EN
  logic          wb_en, rd_collision;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
`endif

  always #5 clk = ~clk;

  mem_pingpong_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .bank_ready(bank_ready), .frame_start(frame_start), .mem_sel(mem_sel),
`ifdef MEM_INPLACE_WB_EN
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rd_collision(rd_collision),
`endif
    .cen_1(cen_1), .wen_1(wen_1), .addr_1(addr_1), .d_1(d_1), .q_1(q_1),
    .cen_2(cen_2), .wen_2(wen_2), .addr_2(addr_2), .d_2(d_2), .q_2(q_2)
  );

  // Single-port SRAM models, 1-cycle read latency.
  logic [DW-1:0] mem1 [0:(2**AW)-1];
  logic [DW-1:0] mem2 [0:(2**AW)-1];
  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    q_1 = '0;
    q_2 = '0;
  end
  always @(posedge clk) begin
    if (cen_1) begin
      if (wen_1) mem1[addr_1] <= d_1;
      else       q_1 <= mem1[addr_1];
    end
    if (cen_2) begin
      if (wen_2) mem2[addr_2] <= d_2;
      else       q_2 <= mem2[addr_2];
    end
  end

  int checks = 0;
  int errors = 0;
  bit checks_on = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Frame-level model: a readable frame, a filling frame, and a swap count.
  logic [DW-1:0] m_rd   [FL];
  logic [DW-1:0] m_fill [FL];
  int            m_fill_n = 0;
  bit            m_have = 1'b0;
  bit            m_full = 1'b0;
  bit            m_sel = 1'b0;
  bit            exp_frame_start = 1'b0;
  bit            exp_rd_valid = 1'b0;
  bit            exp_coll = 1'b0;
  logic [DW-1:0] exp_rd_data = '0;

  always @(posedge clk) begin : p_model
    bit xfer, acc, done, wb;
    if (rst) begin
      m_have = 1'b0; m_full = 1'b0; m_fill_n = 0; m_sel = 1'b0;
      exp_frame_start = 1'b0; exp_rd_valid = 1'b0; exp_coll = 1'b0;
      exp_rd_data = '0;
    end else begin
      xfer = wr_valid && !m_full;
`ifdef MEM_INPLACE_WB_EN
      wb = wb_en && m_have;
`else
      wb = 1'b0;
`endif
      acc = rd_en && m_have && !wb;
      exp_coll     = wb && rd_en;
      exp_rd_valid = acc;
      exp_rd_data  = acc ? m_rd[int'(rd_addr)] : '0;
`ifdef MEM_INPLACE_WB_EN
      if (wb) m_rd[int'(wb_addr)] = wb_data;
`endif
      if (xfer) begin
        m_fill[m_fill_n] = wr_data;
        m_fill_n++;
        if (m_fill_n == FL) begin
          m_full   = 1'b1;
          m_fill_n = 0;
        end
      end
      done = rd_done && m_have;
      if (done) m_have = 1'b0;
      exp_frame_start = m_full && !m_have;
      if (exp_frame_start) begin
        m_rd   = m_fill;
        m_have = 1'b1;
        m_full = 1'b0;
        m_sel  = ~m_sel;
      end
    end
  end

  always @(negedge clk) begin : p_compare
    int n_cen, n_wen;
    if (checks_on && !rst) begin
      chk1("wr_ready", wr_ready, !m_full);
      chk1("bank_ready", bank_ready, m_have);
      chk1("mem_sel", mem_sel, m_sel);
      chk1("frame_start", frame_start, exp_frame_start);
      chk1("rd_valid", rd_valid, exp_rd_valid);
      chk("rd_data", rd_data, exp_rd_data);
      n_cen = int'(wr_valid && !m_full);
      n_wen = n_cen;
`ifdef MEM_INPLACE_WB_EN
      chk1("rd_collision", rd_collision, exp_coll);
      n_cen += int'(rd_en && m_have && !wb_en) + int'(wb_en && m_have);
      n_wen += int'(wb_en && m_have);
`else
      n_cen += int'(rd_en && m_have);
`endif
      chk("cen_count", 32'(int'(cen_1) + int'(cen_2)), 32'(n_cen));
      chk("wen_count", 32'(int'(wen_1) + int'(wen_2)), 32'(n_wen));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_data = '0; rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
`ifdef MEM_INPLACE_WB_EN
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
`endif
  endtask

  task automatic write_word(logic [DW-1:0] v);
    tick();
    idle();
    wr_valid = 1'b1;
    wr_data  = v;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks_on = 1'b1;
    @(negedge clk);
    chk1("reset_mem_sel", mem_sel, 1'b0);
    chk1("reset_bank_ready", bank_ready, 1'b0);
    chk1("reset_wr_ready", wr_ready, 1'b1);

    // Frame 0..7 back-to-back.
    for (int i = 0; i < FL; i++) begin
      write_word(32'(i));
      @(negedge clk);
      chk1("t1_wr_ready", wr_ready, 1'b1);
    end
    tick(); idle();
    @(negedge clk);
    chk1("t1_frame_start", frame_start, 1'b1);
    chk1("t1_mem_sel", mem_sel, 1'b1);
    chk1("t1_bank_ready", bank_ready, 1'b1);

    // Read back addresses 0..7, pipelined.
    for (int i = 0; i <= FL; i++) begin
      tick(); idle();
      if (i < FL) begin
        rd_en = 1'b1;
        rd_addr = AW'(i);
      end
      @(negedge clk);
      if (i > 0) begin
        chk1("t2_rd_valid", rd_valid, 1'b1);
        chk("t2_rd_data", rd_data, 32'(i - 1));
      end
    end

    // Second frame without release: stall in HOLD, then release.
    for (int i = 0; i < FL; i++) write_word(32'(100 + i));
    tick(); idle();
    @(negedge clk);
    chk1("t3_hold_wr_ready", wr_ready, 1'b0);
    tick(); idle(); rd_done = 1'b1;
    tick(); idle();
    @(negedge clk);
    chk1("t3_mem_sel", mem_sel, 1'b0);
    chk1("t3_wr_ready", wr_ready, 1'b1);
    chk1("t3_frame_start", frame_start, 1'b1);
    tick(); idle(); rd_en = 1'b1; rd_addr = 4'd2;
    tick(); idle();
    @(negedge clk);
    chk("t3_rd_data", rd_data, 32'd102);

    // Last write coincides with release: swap without stall.
    for (int i = 0; i < FL; i++) begin
      write_word(32'(200 + i));
      rd_done = (i == FL - 1);
      @(negedge clk);
      chk1("t4_wr_ready", wr_ready, 1'b1);
    end
    tick(); idle();
    @(negedge clk);
    chk1("t4_frame_start", frame_start, 1'b1);
    chk1("t4_mem_sel", mem_sel, 1'b1);
    chk1("t4_wr_ready", wr_ready, 1'b1);
    tick(); idle(); rd_en = 1'b1; rd_addr = 4'd7;
    tick(); idle();
    @(negedge clk);
    chk("t4_rd_data", rd_data, 32'd207);

    // Reset mid-frame discards partial data.
    for (int i = 0; i < 5; i++) write_word(32'(50 + i));
    tick(); idle(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk1("t5_mem_sel", mem_sel, 1'b0);
    chk1("t5_bank_ready", bank_ready, 1'b0);
    for (int i = 0; i < FL; i++) begin
      write_word(32'(60 + i));
      @(negedge clk);
      chk1("t5_no_early_start", frame_start, 1'b0);
    end
    tick(); idle();
    @(negedge clk);
    chk1("t5_frame_start", frame_start, 1'b1);
    chk1("t5_sel_after", mem_sel, 1'b1);

`ifdef MEM_INPLACE_WB_EN
    tick(); idle();
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hAA;
    rd_en = 1'b1; rd_addr = 4'd3;
    tick(); idle();
    @(negedge clk);
    chk1("t6_collision", rd_collision, 1'b1);
    chk1("t6_rd_valid", rd_valid, 1'b0);
    tick(); idle(); rd_en = 1'b1; rd_addr = 4'd3;
    tick(); idle();
    @(negedge clk);
    chk("t6_rd_data", rd_data, 32'hAA);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      tick(); idle();
      rst      = ($urandom_range(0, 399) == 0);
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = $urandom;
      rd_en    = $urandom_range(0, 1) == 1;
      rd_addr  = AW'($urandom_range(0, FL - 1));
      rd_done  = ($urandom_range(0, 15) == 0);
`ifdef MEM_INPLACE_WB_EN
      wb_en    = ($urandom_range(0, 7) == 0);
      wb_addr  = AW'($urandom_range(0, FL - 1));
      wb_data  = $urandom;
`endif
    end
    tick(); idle(); rst = 1'b0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
